cpu_sequencer: RTL and testbench

Multi-cycle control/execute stage that sits directly upstream of the 16x16 register file: fetches 16-bit instructions over a request/valid port, drives the register file's two synchronous read ports, executes ALU/branch operations and issues the single write-back. Owns the program counter and halt state; needs no forwarding because the register file write always completes before the next read is issued.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/cpu_alu.sv | 28 ++
 rtl/cpu_sequencer.sv | 122 ++++++++++++
 tb/tb_cpu_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu sequencer: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // ADD through MOV all end with a register file write.
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational execute unit: result for every register-writing opcode.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  imm8,
  output logic [15:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      OP_LDI:  result = {8'h00, imm8};
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back controller in front of the
// 16x16 register file; owns the PC, instruction register and halt state.
//
// state     | meaning
// FETCH     | request instruction at PC, wait for imem_valid
// DECODE    | read addresses presented to the register file
// EXEC      | operands valid, compute result, resolve branches
// WB        | single-cycle register file write
// HALT      | terminal after HLT, left only by reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            imem_valid,
  output logic [3:0]      rf_addr_read1,
  output logic [3:0]      rf_addr_read2,
  input  logic [15:0]     rf_rdata1,
  input  logic [15:0]     rf_rdata2,
  output logic            rf_we,
  output logic [3:0]      rf_addr_write,
  output logic [15:0]     rf_wdata,
  output logic            retired,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [15:0]     alu_result;
  logic [3:0]      op;
  logic [3:0]      rd;
  logic [7:0]      imm8;
  logic            branch_taken;

  assign op   = ir[OP_HI:OP_LO];
  assign rd   = ir[RD_HI:RD_LO];
  assign imm8 = ir[IMM_HI:IMM_LO];

  // BEQZ tests R[rd], so port 1 is steered to the rd field for it.
  assign rf_addr_read1 = (op == OP_BEQZ) ? rd : ir[RS1_HI:RS1_LO];
  assign rf_addr_read2 = ir[RS2_HI:RS2_LO];
  assign imem_addr     = pc;

  assign branch_taken = (op == OP_JMP) || ((op == OP_BEQZ) && (rf_rdata1 == 16'd0));

  cpu_alu u_alu (
    .op     (op),
    .a      (rf_rdata1),
    .b      (rf_rdata2),
    .imm8   (imm8),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HLT)        state_next = ST_HALT;
        else if (op_writes(op))  state_next = ST_WB;
        else                     state_next = ST_FETCH;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= '0;
      ir            <= '0;
      rf_we         <= 1'b0;
      rf_addr_write <= '0;
      rf_wdata      <= '0;
      retired       <= 1'b0;
      halted        <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      retired <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (imem_valid) begin
            ir <= imem_data;
            pc <= pc + PC_W'(1);
          end
        end
        ST_EXEC: begin
          if (branch_taken) pc <= PC_W'(imm8);
          if (op == OP_HLT) begin
            halted <= 1'b1;
          end else if (op_writes(op)) begin
            rf_we         <= 1'b1;
            rf_addr_write <= rd;
            rf_wdata      <= alu_result;
          end else begin
            retired <= 1'b1;
          end
        end
        ST_WB:   retired <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer against an instruction-level reference
// interpreter, with a simple synchronous register file model attached.
module tb_cpu_sequencer;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data = '0;
  logic            imem_valid = 1'b0;
  logic [3:0]      rf_addr_read1, rf_addr_read2;
  logic [15:0]     rf_rdata1, rf_rdata2;
  logic            rf_we;
  logic [3:0]      rf_addr_write;
  logic [15:0]     rf_wdata;
  logic            retired;
  logic            halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]     rf_mem [16] = '{default: 16'h0000};
  logic [15:0]     mref   [16] = '{default: 16'h0000};
  logic [PC_W-1:0] pc_ref = '0;
  logic [3:0]      last_wa;
  logic [15:0]     last_wd;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .rf_addr_read1 (rf_addr_read1),
    .rf_addr_read2 (rf_addr_read2),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .rf_we         (rf_we),
    .rf_addr_write (rf_addr_write),
    .rf_wdata      (rf_wdata),
    .retired       (retired),
    .halted        (halted)
  );

  // Register file: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr_write] <= rf_wdata;
    rf_rdata1 <= rf_mem[rf_addr_read1];
    rf_rdata2 <= rf_mem[rf_addr_read2];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Feeds one instruction at the next fetch, then follows it to its end,
  // comparing fetch address, cycle count, write-back and retirement with
  // what the instruction-level model says.
  task automatic run_instr(input logic [15:0] instr, input int delay);
    logic [3:0]  op, rd, rs1, rs2;
    logic [7:0]  imm;
    logic [15:0] a, b, r;
    logic        writes;
    int          n, nwe, nret;
    op = instr[15:12]; rd = instr[11:8]; rs1 = instr[7:4]; rs2 = instr[3:0];
    imm = instr[7:0];
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("fetch_timeout", 32'(imem_req), 32'd1);
      return;
    end
    chk("fetch_addr", 32'(imem_addr), 32'(pc_ref));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("fetch_hold_req", 32'(imem_req), 32'd1);
      chk("fetch_hold_addr", 32'(imem_addr), 32'(pc_ref));
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'($urandom);
    chk("rd_addr1", 32'(rf_addr_read1), 32'((op == 4'hA) ? rd : rs1));
    chk("rd_addr2", 32'(rf_addr_read2), 32'(rs2));

    // instruction-level reference
    a = mref[rs1]; b = mref[rs2];
    writes = (op >= 4'h1) && (op <= 4'h9);
    case (op)
      4'h1: r = a + b;
      4'h2: r = a - b;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = a << b[3:0];
      4'h7: r = a >> b[3:0];
      4'h8: r = {8'h00, imm};
      4'h9: r = a;
      default: r = 16'h0000;
    endcase
    pc_ref = pc_ref + PC_W'(1);
    if ((op == 4'hA && mref[rd] == 16'h0000) || op == 4'hB) pc_ref = PC_W'(imm);

    n = 1; nwe = 0; nret = 0;
    while (n < 12) begin
      if (rf_we) begin
        nwe++;
        last_wa = rf_addr_write;
        last_wd = rf_wdata;
      end
      if (retired) nret++;
      if (imem_req || halted) break;
      @(negedge clk);
      n++;
    end
    chk("instr_cycles", 32'(n), writes ? 32'd4 : 32'd3);
    chk("we_count", 32'(nwe), writes ? 32'd1 : 32'd0);
    if (writes && nwe == 1) begin
      chk("wb_addr", 32'(last_wa), 32'(rd));
      chk("wb_data", 32'(last_wd), 32'(r));
    end
    chk("retire_count", 32'(nret), (op == 4'hF) ? 32'd0 : 32'd1);
    chk("retire_at_end", 32'(retired), (op == 4'hF) ? 32'd0 : 32'd1);
    if (writes) mref[rd] = r;
  endtask

  initial begin
    logic [15:0] instr;
    logic [3:0]  rop;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_ra1", 32'(rf_addr_read1), 32'd0);
    chk("rst_ra2", 32'(rf_addr_read2), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_wa", 32'(rf_addr_write), 32'd0);
    chk("rst_wd", 32'(rf_wdata), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("first_fetch_req", 32'(imem_req), 32'd1);
    chk("first_fetch_addr", 32'(imem_addr), 32'd0);

    // LDI/LDI/ADD
    run_instr(16'h8105, 0);
    run_instr(16'h8203, 0);
    run_instr(16'h1312, 0);
    chk("add_wa", 32'(last_wa), 32'd3);
    chk("add_wd", 32'(last_wd), 32'h0008);

    // SUB / SHL / SHR
    run_instr(16'h8103, 0);
    run_instr(16'h8205, 0);
    run_instr(16'h2412, 0);
    chk("sub_wd", 32'(last_wd), 32'hFFFE);
    run_instr(16'h6512, 1);
    chk("shl_wd", 32'(last_wd), 32'h0060);
    run_instr(16'h7652, 0);
    chk("shr_wd", 32'(last_wd), 32'h0003);

    // branches
    run_instr(16'h8000, 0);
    run_instr(16'hA020, 0);
    chk("beqz_taken_addr", 32'(imem_addr), 32'h20);
    run_instr(16'hA140, 0);
    chk("beqz_not_taken_addr", 32'(imem_addr), 32'h21);
    run_instr(16'hB0FF, 0);
    chk("jmp_addr", 32'(imem_addr), 32'hFF);
    run_instr(16'h0000, 0);
    chk("pc_wrap_addr", 32'(imem_addr), 32'h00);

    // slow instruction memory
    run_instr(16'h8777, 3);
    chk("delayed_wd", 32'(last_wd), 32'h0077);

    // random programs
    for (int i = 0; i < 200; i++) begin
      rop   = 4'($urandom_range(0, 14));
      instr = {rop, 12'($urandom)};
      run_instr(instr, int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++) chk("rf_vs_model", 32'(rf_mem[i]), 32'(mref[i]));

    // reset while in WB
    run_instr(16'h8711, 0);
    n_tests = n_tests;
    while (!imem_req) @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = 16'h87A5;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wb_we_before_rst", 32'(rf_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_wb_we", 32'(rf_we), 32'd0);
    chk("rst_wb_wd", 32'(rf_wdata), 32'd0);
    chk("rst_wb_addr", 32'(imem_addr), 32'd0);
    chk("rst_wb_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pc_ref  = '0;
    run_instr(16'h0000, 0);
    chk("rst_wb_no_write", 32'(rf_mem[7]), 32'h0011);

    // halt, then stray responses
    run_instr(16'hF000, 1);
    chk("halted", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_data  = 16'h8155;
      @(negedge clk);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_we", 32'(rf_we), 32'd0);
      chk("halt_retired", 32'(retired), 32'd0);
    end
    imem_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
